// File: rtl/wavelet_pkg.sv
// Shared defaults, sym4 synthesis taps and small helpers for the wavelet
// reconstruction stages.
package wavelet_pkg;

  localparam int DATA_W_DEF    = 48;
  localparam int COEF_W_DEF    = 25;
  localparam int COEF_FRAC_DEF = 23;
  localparam int SYM4_NTAPS    = 8;

  // sym4 synthesis taps in Q1.23, tap i at bits [i*25 +: 25] (tap 7 listed first)
  localparam logic [SYM4_NTAPS*COEF_W_DEF-1:0] SYM4_REC_LO = {
    -25'sd635569,  -25'sd248601,  25'sd4174328, 25'sd6742249,
     25'sd2498612, -25'sd832314, -25'sd105730,  25'sd270306
  };
  localparam logic [SYM4_NTAPS*COEF_W_DEF-1:0] SYM4_REC_HI = {
    -25'sd270306,  -25'sd105730,  25'sd832314,  25'sd2498612,
    -25'sd6742249,  25'sd4174328, 25'sd248601, -25'sd635569
  };

  // Accumulator wide enough that the full sum of products never overflows.
  function automatic int acc_width(input int dw, input int cw, input int ntaps);
    return dw + cw + $clog2(ntaps) + 1;
  endfunction

  // Half-LSB offset added before the right shift (round half up).
  function automatic longint rnd_const(input int frac);
    return (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
  endfunction

endpackage

// File: rtl/wavelet_rec_mac.sv
// One polyphase branch of the synthesis filter: NTAPS/2 low-pass plus
// NTAPS/2 high-pass products, registered, then summed and registered again.
// PHASE selects taps 2j (even output) or 2j+1 (odd output).
module wavelet_rec_mac
  import wavelet_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int NTAPS  = 8,
  parameter int PHASE  = 0,
  parameter int ACC_W  = acc_width(DATA_W, COEF_W, NTAPS),
  parameter logic [NTAPS*COEF_W-1:0] REC_LO = '0,
  parameter logic [NTAPS*COEF_W-1:0] REC_HI = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic [NTAPS/2-1:0][DATA_W-1:0]  a_hist,
  input  logic [NTAPS/2-1:0][DATA_W-1:0]  d_hist,
  output logic signed [ACC_W-1:0]         sum
);

  localparam int N  = NTAPS / 2;
  localparam int PW = DATA_W + COEF_W;

  logic signed [PW-1:0]    prod_a [N];
  logic signed [PW-1:0]    prod_d [N];
  logic signed [ACC_W-1:0] acc;

  // product stage: full-precision signed products of history and taps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) begin
        prod_a[j] <= '0;
        prod_d[j] <= '0;
      end
    end else if (clr) begin
      for (int j = 0; j < N; j++) begin
        prod_a[j] <= '0;
        prod_d[j] <= '0;
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        prod_a[j] <= PW'($signed(a_hist[j])) *
                     PW'($signed(REC_LO[(2*j+PHASE)*COEF_W +: COEF_W]));
        prod_d[j] <= PW'($signed(d_hist[j])) *
                     PW'($signed(REC_HI[(2*j+PHASE)*COEF_W +: COEF_W]));
      end
    end
  end

  // adder tree over all products, sign-extended to the accumulator width
  always_comb begin
    acc = '0;
    for (int j = 0; j < N; j++)
      acc = acc + ACC_W'(prod_a[j]) + ACC_W'(prod_d[j]);
  end

  // sum stage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   sum <= '0;
    else if (clr) sum <= '0;
    else          sum <= acc;
  end

endmodule

// File: rtl/wavelet_rec_stage.sv
// One-level inverse wavelet synthesis stage: accepts (a, d) pairs at up to
// one per two cycles and emits two reconstructed samples (even, then odd).
// Optional macro WAVELET_REC_SAT_EN: saturate instead of wrap on narrowing
// and expose a sat_flag output that pulses with a clipped sample.
module wavelet_rec_stage
  import wavelet_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int COEF_W    = COEF_W_DEF,
  parameter int COEF_FRAC = COEF_FRAC_DEF,
  parameter int NTAPS     = 8,
  parameter logic [NTAPS*COEF_W-1:0] REC_LO = '0,
  parameter logic [NTAPS*COEF_W-1:0] REC_HI = '0,
  parameter int WARMUP    = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] d_in,
  output logic                     dout_valid,
  output logic signed [DATA_W-1:0] dout,
  output logic                     overrun
`ifdef WAVELET_REC_SAT_EN
  ,
  output logic                     sat_flag
`endif
);

  localparam int N      = NTAPS / 2;
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, NTAPS);
  localparam int WCW    = $clog2(WARMUP + 2);
  localparam int STAGES = 3;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(rnd_const(COEF_FRAC));

  logic                          accept;
  logic                          vld_in;
  logic [STAGES:1]               vld_pipe;
  logic [WCW-1:0]                warm_left;
  logic [N-1:0][DATA_W-1:0]      a_hist;
  logic [N-1:0][DATA_W-1:0]      d_hist;
  logic signed [ACC_W-1:0]       sum_e;
  logic signed [ACC_W-1:0]       sum_o;
  logic signed [DATA_W-1:0]      y_e;
  logic signed [DATA_W-1:0]      y_o;
  logic signed [DATA_W-1:0]      odd_q;
  logic                          odd_pend;

  // a pair offered alongside flush is discarded, never accepted
  assign accept = din_valid && din_ready && !flush;
  // pairs still inside the warm-up window carry no output tag
  assign vld_in = accept && (warm_left == '0);

  // handshake: one idle cycle after every acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     din_ready <= 1'b1;
    else if (flush) din_ready <= 1'b1;
    else            din_ready <= !accept;
  end

  // sticky overrun on a pair offered while not ready (flush cycle excluded)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 overrun <= 1'b0;
    else if (din_valid && !din_ready && !flush) overrun <= 1'b1;
  end

  // coefficient history, newest pair in entry 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_hist <= '0;
      d_hist <= '0;
    end else if (flush) begin
      a_hist <= '0;
      d_hist <= '0;
    end else if (accept) begin
      for (int j = N - 1; j > 0; j--) begin
        a_hist[j] <= a_hist[j-1];
        d_hist[j] <= d_hist[j-1];
      end
      a_hist[0] <= a_in;
      d_hist[0] <= d_in;
    end
  end

  // warm-up countdown of suppressed pairs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           warm_left <= WCW'(WARMUP);
    else if (flush)                       warm_left <= WCW'(WARMUP);
    else if (accept && warm_left != '0)   warm_left <= warm_left - 1'b1;
  end

  // valid tags track history -> products -> sums
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     vld_pipe <= '0;
    else if (flush) vld_pipe <= '0;
    else            vld_pipe <= {vld_pipe[STAGES-1:1], vld_in};
  end

  wavelet_rec_mac #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .PHASE(0),
    .ACC_W(ACC_W), .REC_LO(REC_LO), .REC_HI(REC_HI)
  ) u_even (
    .clk(clk), .rst_n(rst_n), .clr(flush),
    .a_hist(a_hist), .d_hist(d_hist), .sum(sum_e)
  );

  wavelet_rec_mac #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .PHASE(1),
    .ACC_W(ACC_W), .REC_LO(REC_LO), .REC_HI(REC_HI)
  ) u_odd (
    .clk(clk), .rst_n(rst_n), .clr(flush),
    .a_hist(a_hist), .d_hist(d_hist), .sum(sum_o)
  );

`ifdef WAVELET_REC_SAT_EN
  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] full_e;
  logic signed [ACC_W-1:0] full_o;
  logic                    clip_e;
  logic                    clip_o;
  logic                    clip_o_q;

  assign full_e = (sum_e + RND) >>> COEF_FRAC;
  assign full_o = (sum_o + RND) >>> COEF_FRAC;
  // in range only when every bit above the DATA_W sign bit matches it
  assign clip_e = !((&full_e[ACC_W-1:DATA_W-1]) || !(|full_e[ACC_W-1:DATA_W-1]));
  assign clip_o = !((&full_o[ACC_W-1:DATA_W-1]) || !(|full_o[ACC_W-1:DATA_W-1]));
  assign y_e = clip_e ? (full_e[ACC_W-1] ? SAT_MIN : SAT_MAX) : full_e[DATA_W-1:0];
  assign y_o = clip_o ? (full_o[ACC_W-1] ? SAT_MIN : SAT_MAX) : full_o[DATA_W-1:0];

  // clip indication follows the sample it belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
      clip_o_q <= 1'b0;
    end else if (flush) begin
      sat_flag <= 1'b0;
      clip_o_q <= 1'b0;
    end else if (vld_pipe[STAGES]) begin
      sat_flag <= clip_e;
      clip_o_q <= clip_o;
    end else if (odd_pend) begin
      sat_flag <= clip_o_q;
    end else begin
      sat_flag <= 1'b0;
    end
  end
`else
  // two's-complement wrap: keep only the low DATA_W bits
  assign y_e = DATA_W'((sum_e + RND) >>> COEF_FRAC);
  assign y_o = DATA_W'((sum_o + RND) >>> COEF_FRAC);
`endif

  // output serializer: even sample first, odd sample the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      odd_q      <= '0;
      odd_pend   <= 1'b0;
    end else if (flush) begin
      dout_valid <= 1'b0;
      odd_q      <= '0;
      odd_pend   <= 1'b0;
    end else if (vld_pipe[STAGES]) begin
      dout       <= y_e;
      odd_q      <= y_o;
      dout_valid <= 1'b1;
      odd_pend   <= 1'b1;
    end else if (odd_pend) begin
      dout       <= odd_q;
      dout_valid <= 1'b1;
      odd_pend   <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wavelet_rec_stage.sv
// Directed bench for wavelet_rec_stage: three instances share one input
// stream (WARMUP=0 and WARMUP=3 with sym4 taps, WARMUP=0 with all taps 1.0).
module tb_wavelet_rec_stage;
  import wavelet_pkg::*;

  localparam int DW = 48;
  localparam logic [8*25-1:0] UNIT_TAPS = {8{25'd8388608}};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic din_valid = 1'b0;
  logic signed [DW-1:0] a_in = '0;
  logic signed [DW-1:0] d_in = '0;

  logic rdy0, vld0, ovr0, rdy3, vld3, ovr3, rdys, vlds, ovrs;
  logic signed [DW-1:0] dout0, dout3, douts;
`ifdef WAVELET_REC_SAT_EN
  logic sat0, sat3, sats;
`endif

  wavelet_rec_stage #(.REC_LO(SYM4_REC_LO), .REC_HI(SYM4_REC_HI), .WARMUP(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .din_valid(din_valid), .din_ready(rdy0),
    .a_in(a_in), .d_in(d_in), .dout_valid(vld0), .dout(dout0), .overrun(ovr0)
`ifdef WAVELET_REC_SAT_EN
    , .sat_flag(sat0)
`endif
  );

  wavelet_rec_stage #(.REC_LO(SYM4_REC_LO), .REC_HI(SYM4_REC_HI), .WARMUP(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .din_valid(din_valid), .din_ready(rdy3),
    .a_in(a_in), .d_in(d_in), .dout_valid(vld3), .dout(dout3), .overrun(ovr3)
`ifdef WAVELET_REC_SAT_EN
    , .sat_flag(sat3)
`endif
  );

  wavelet_rec_stage #(.REC_LO(UNIT_TAPS), .REC_HI(UNIT_TAPS), .WARMUP(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .din_valid(din_valid), .din_ready(rdys),
    .a_in(a_in), .d_in(d_in), .dout_valid(vlds), .dout(douts), .overrun(ovrs)
`ifdef WAVELET_REC_SAT_EN
    , .sat_flag(sats)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected sym4 taps, written out independently of the packed constants
  longint LO [8] = '{270306, -105730, -832314, 2498612, 6742249, 4174328, -248601, -635569};
  longint HI [8] = '{-635569, 248601, 4174328, -6742249, 2498612, 832314, -105730, -270306};

  longint pa [20];
  longint pd [20];

  longint q0 [$];
  longint q3 [$];
  int     t0 [$];
  int     t3 [$];

  // collect valid output samples with their cycle stamps
  always @(negedge clk) begin
    if (vld0) begin q0.push_back(longint'(dout0)); t0.push_back(cyc); end
    if (vld3) begin q3.push_back(longint'(dout3)); t3.push_back(cyc); end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    q0.delete(); q3.delete(); t0.delete(); t3.delete();
  endtask

  // one pair, then one idle cycle: the maximum accepted rate
  task automatic drive_pair(input longint a, input longint d, output int acc_cyc);
    @(posedge clk); #1;
    din_valid = 1'b1; a_in = DW'(a); d_in = DW'(d); acc_cyc = cyc;
    @(posedge clk); #1;
    din_valid = 1'b0; a_in = '0; d_in = '0;
  endtask

  task automatic do_flush();
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // spec formula evaluated on the recorded pairs (history zero before pair 0)
  function automatic longint model(input int k);
    int p = k / 2;
    int ph = k % 2;
    longint s = 0;
    for (int j = 0; j < 4; j++)
      if (p - j >= 0) s += pa[p-j] * LO[2*j+ph] + pd[p-j] * HI[2*j+ph];
    return (s + (64'sd1 <<< 22)) >>> 23;
  endfunction

  longint exp_wide;
  int acc, dummy;

  initial begin
    // ---- reset state
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_ready", rdy0, 1);
    check("rst_valid", vld0, 0);
    check("rst_dout", dout0, 0);
    check("rst_overrun", ovr0, 0);
    check("rst_ready_w3", rdy3 & rdys, 1);
    check("rst_overrun_w3", ovr3 | ovrs, 0);
`ifdef WAVELET_REC_SAT_EN
    check("rst_sat_flag", sat0 | sat3 | sats, 0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;

    // ---- approximation impulse on the WARMUP=0 instance
    clear_q();
    drive_pair(64'sd1 <<< 23, 0, acc);
    repeat (7) drive_pair(0, 0, dummy);
    idle(12);
    check("imp_a_cnt", q0.size(), 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("imp_a_%0d", i), (i < q0.size()) ? q0[i] : -1, (i < 8) ? LO[i] : 0);
    check("imp_a_lat_even", (t0.size() > 0) ? t0[0] - acc : -1, 4);
    check("imp_a_lat_odd", (t0.size() > 1) ? t0[1] - acc : -1, 5);

    // ---- detail impulse
    do_flush();
    clear_q();
    drive_pair(0, 64'sd1 <<< 23, acc);
    repeat (7) drive_pair(0, 0, dummy);
    idle(12);
    check("imp_d_cnt", q0.size(), 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("imp_d_%0d", i), (i < q0.size()) ? q0[i] : -1, (i < 8) ? HI[i] : 0);

    // ---- full-rate random stream
    do_flush();
    clear_q();
    for (int p = 0; p < 20; p++) begin
      pa[p] = longint'(int'($urandom)) >>> 1;
      pd[p] = longint'(int'($urandom)) >>> 1;
      drive_pair(pa[p], pd[p], dummy);
    end
    idle(12);
    check("str_w3_cnt", q3.size(), 34);
    check("str_w3_span", (t3.size() > 0) ? t3[t3.size()-1] - t3[0] : -1, 33);
    for (int k = 0; k < 34; k++)
      check($sformatf("str_w3_%0d", k), (k < q3.size()) ? q3[k] : -1, model(k + 6));
    check("str_w0_cnt", q0.size(), 40);
    for (int k = 0; k < 40; k++)
      check($sformatf("str_w0_%0d", k), (k < q0.size()) ? q0[k] : -1, model(k));

    // ---- flush mid-stream, with a pair offered in the flush cycle
    do_flush();
    for (int p = 0; p < 4; p++)
      drive_pair(longint'(int'($urandom)) >>> 1, longint'(int'($urandom)) >>> 1, dummy);
    @(posedge clk); #1;
    din_valid = 1'b1; a_in = DW'(64'sd12345); d_in = DW'(-64'sd777);
    @(posedge clk); #1;
    flush = 1'b1; a_in = DW'(64'sd1 <<< 23);
    @(posedge clk); #1;
    flush = 1'b0; din_valid = 1'b0; a_in = '0; d_in = '0;
    clear_q();
    @(negedge clk);
    check("flush_ready", rdy0, 1);
    idle(8);
    check("flush_leak_w0", q0.size(), 0);
    check("flush_leak_w3", q3.size(), 0);
    check("flush_no_overrun", ovr0, 0);
    drive_pair(64'sd1 <<< 23, 0, acc);
    repeat (7) drive_pair(0, 0, dummy);
    idle(12);
    check("flush_imp_cnt", q0.size(), 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("flush_imp_%0d", i), (i < q0.size()) ? q0[i] : -1, (i < 8) ? LO[i] : 0);
    check("flush_w3_cnt", q3.size(), 10);
    check("flush_w3_first_lat", (t3.size() > 0) ? t3[0] - acc : -1, 10);
    check("flush_w3_s0", (q3.size() > 0) ? q3[0] : -1, LO[6]);
    check("flush_w3_s1", (q3.size() > 1) ? q3[1] : -1, LO[7]);

    // ---- narrowing: all-ones taps with full-scale inputs
    do_flush();
    drive_pair((64'sd1 <<< 47) - 1, (64'sd1 <<< 47) - 1, acc);
`ifdef WAVELET_REC_SAT_EN
    exp_wide = (64'sd1 <<< 47) - 1;
`else
    exp_wide = -2;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("narrow_even_valid", vlds, 1);
    check("narrow_even", douts, exp_wide);
`ifdef WAVELET_REC_SAT_EN
    check("narrow_even_flag", sats, 1);
`endif
    @(negedge clk);
    check("narrow_odd_valid", vlds, 1);
    check("narrow_odd", douts, exp_wide);
`ifdef WAVELET_REC_SAT_EN
    check("narrow_odd_flag", sats, 1);
`endif

    // ---- overrun: pairs on two consecutive cycles, second one dropped
    do_flush();
    clear_q();
    @(posedge clk); #1;
    din_valid = 1'b1; a_in = DW'(64'sd1 <<< 23); d_in = '0;
    @(posedge clk); #1;
    a_in = DW'(64'sd5 <<< 23); d_in = DW'(64'sd3 <<< 23);
    @(negedge clk);
    check("ovr_ready_low", rdy0, 0);
    @(posedge clk); #1;
    din_valid = 1'b0; a_in = '0; d_in = '0;
    check("ovr_set", ovr0, 1);
    repeat (7) drive_pair(0, 0, dummy);
    idle(12);
    check("ovr_drop_cnt", q0.size(), 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("ovr_drop_%0d", i), (i < q0.size()) ? q0[i] : -1, (i < 8) ? LO[i] : 0);
    do_flush();
    idle(4);
    check("ovr_sticky", ovr0, 1);

    // ---- reset mid-operation clears everything, overrun included
    drive_pair(64'sd1 <<< 23, 0, dummy);
    rst_n = 1'b0;
    clear_q();
    @(negedge clk);
    check("rst2_overrun", ovr0, 0);
    check("rst2_ready", rdy0, 1);
    check("rst2_valid", vld0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(8);
    check("rst2_no_output", q0.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
